// File: rtl/equiv_check_sequencer.sv
// equiv_check_sequencer: feeds LFSR stimulus to a reference and a netlist copy of a
// combinational block, compares their outputs per vector and records the first failure.
//   state    | meaning
//   S_IDLE   | waiting for start, results held
//   S_DRIVE  | shifting WORDS LFSR words into stim
//   S_SETTLE | stim held while both instances settle
//   S_CHECK  | compare y_ref against y_dut, advance vector
//   S_DONE   | run complete, results valid
module equiv_check_sequencer #(
  parameter int          IN_W    = 232,
  parameter int          OUT_W   = 1394,
  parameter int          NUM_VEC = 256,
  parameter int          SETTLE  = 2,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_cnt,
  output logic             fail_valid,
  output logic [15:0]      fail_idx,
  output logic [IN_W-1:0]  fail_stim
);
  localparam int          WORDS     = (IN_W + 31) / 32;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam logic [15:0] LAST_VEC  = 16'(NUM_VEC - 1);
  localparam logic [15:0] DRIVE_LD  = 16'(WORDS - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic [IN_W-1:0] fail_stim_q, fail_stim_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     vec_idx_q, vec_idx_d;
  logic [15:0]     mismatch_cnt_q, mismatch_cnt_d;
  logic [15:0]     fail_idx_q, fail_idx_d;
  logic            fail_valid_q, fail_valid_d;
  logic            outputs_differ;

  assign outputs_differ = (y_ref != y_dut);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED_EFF;
      stim_q         <= '0;
      fail_stim_q    <= '0;
      cnt_q          <= '0;
      vec_idx_q      <= '0;
      mismatch_cnt_q <= '0;
      fail_idx_q     <= '0;
      fail_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      stim_q         <= stim_d;
      fail_stim_q    <= fail_stim_d;
      cnt_q          <= cnt_d;
      vec_idx_q      <= vec_idx_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      fail_idx_q     <= fail_idx_d;
      fail_valid_q   <= fail_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    stim_d         = stim_q;
    fail_stim_d    = fail_stim_q;
    cnt_d          = cnt_q;
    vec_idx_d      = vec_idx_q;
    mismatch_cnt_d = mismatch_cnt_q;
    fail_idx_d     = fail_idx_q;
    fail_valid_d   = fail_valid_q;

    // abort overrides everything, including a restart from DONE
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_idx_d      = '0;
            mismatch_cnt_d = '0;
            fail_valid_d   = 1'b0;
            fail_idx_d     = '0;
            fail_stim_d    = '0;
            cnt_d          = DRIVE_LD;
            state_d        = S_DRIVE;
          end
        end
        S_DRIVE: begin
          stim_d = IN_W'({stim_q, lfsr_q});
          lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
          if (cnt_q == 16'd0) begin
            cnt_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 16'd0) state_d = S_CHECK;
          else                cnt_d   = cnt_q - 16'd1;
        end
        S_CHECK: begin
          if (outputs_differ) begin
            if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_idx_d   = vec_idx_q;
              fail_stim_d  = stim_q;
            end
          end
          if (vec_idx_q == LAST_VEC) begin
            state_d = S_DONE;
          end else begin
            vec_idx_d = vec_idx_q + 16'd1;
            cnt_d     = DRIVE_LD;
            state_d   = S_DRIVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign stim         = stim_q;
  assign stim_valid   = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign busy         = (state_q == S_DRIVE) || stim_valid;
  assign done         = (state_q == S_DONE);
  assign pass         = done && (mismatch_cnt_q == 16'd0);
  assign mismatch_cnt = mismatch_cnt_q;
  assign fail_valid   = fail_valid_q;
  assign fail_idx     = fail_idx_q;
  assign fail_stim    = fail_stim_q;
endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Scoreboard bench for equiv_check_sequencer: expected stimulus vectors come from a
// bench LFSR model, queued at start and popped as each vector becomes valid.
module tb_equiv_check_sequencer;
  localparam int          IN_W    = 232;
  localparam int          OUT_W   = 1394;
  localparam int          NUM_VEC = 256;
  localparam int          SETTLE  = 2;
  localparam logic [31:0] SEED    = 32'hACE1_0001;
  localparam int          WORDS   = 8;
  localparam int          PER_VEC = WORDS + SETTLE + 1;
  localparam int          S_NVEC  = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [IN_W-1:0]  stim, fail_stim;
  logic             stim_valid, busy, done, pass, fail_valid;
  logic [OUT_W-1:0] y_ref, y_dut;
  logic [15:0]      mismatch_cnt, fail_idx;

  logic             s_start, s_abort;
  logic [IN_W-1:0]  s_stim, s_fail_stim;
  logic             s_stim_valid, s_busy, s_done, s_pass, s_fail_valid;
  logic [OUT_W-1:0] s_y_ref, s_y_dut;
  logic [15:0]      s_mismatch_cnt, s_fail_idx;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               cur_vec;
  logic [NUM_VEC-1:0] bad_vec;
  logic [31:0]      m_lfsr;
  logic [IN_W-1:0]  exp_q[$];
  int               cyc;

  always #5 clk = ~clk;

  equiv_check_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC),
                          .SETTLE(SETTLE), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stim(stim), .stim_valid(stim_valid), .y_ref(y_ref), .y_dut(y_dut),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_stim(fail_stim));

  equiv_check_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(S_NVEC),
                          .SETTLE(SETTLE), .SEED(32'h0)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .stim(s_stim), .stim_valid(s_stim_valid), .y_ref(s_y_ref), .y_dut(s_y_dut),
    .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_cnt(s_mismatch_cnt),
    .fail_valid(s_fail_valid), .fail_idx(s_fail_idx), .fail_stim(s_fail_stim));

  // reference output is a fixed function of stim; the netlist copy can be corrupted per vector
  always_comb begin
    y_ref = OUT_W'({7{stim}});
    y_dut = y_ref;
    if (cur_vec >= 0 && cur_vec < NUM_VEC && bad_vec[cur_vec[7:0]]) y_dut[0] = ~y_ref[0];
  end

  assign s_y_ref = OUT_W'({7{s_stim}});
  assign s_y_dut = ~s_y_ref;

  task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic gen_vec(output logic [IN_W-1:0] v);
    logic [IN_W+31:0] t;
    v = '0;
    for (int w = 0; w < WORDS; w++) begin
      t      = {v, m_lfsr};
      v      = t[IN_W-1:0];
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic run_main(input int nvec, input int abort_vec, input bit poke_start,
                          output int cycles);
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] first_stim;
    logic            prev_sv;
    bit              first_seen;
    int              exp_bad, first_idx, gen;
    gen = (abort_vec >= 0) ? abort_vec + 1 : nvec;
    for (int i = 0; i < gen; i++) begin
      gen_vec(v);
      exp_q.push_back(v);
    end
    exp_bad = 0; first_idx = 0; first_stim = '0; first_seen = 0;
    cur_vec = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0; prev_sv = 1'b0;
    while (!done && cycles < nvec * PER_VEC + 20) begin
      start = 1'b0;
      if (stim_valid && !prev_sv) begin
        cur_vec++;
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1'b1, 1'b0);
          v = '0;
        end else begin
          v = exp_q.pop_front();
        end
        check("stim", stim, v);
        if (cur_vec == abort_vec) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_busy", busy, 1'b0);
          check("abort_done", done, 1'b0);
          check("abort_cnt", mismatch_cnt, 16'(exp_bad));
          @(negedge clk);
          check("abort_hold_cnt", mismatch_cnt, 16'(exp_bad));
          return;
        end
        if (bad_vec[cur_vec[7:0]]) begin
          exp_bad++;
          if (!first_seen) begin
            first_seen = 1;
            first_idx  = cur_vec;
            first_stim = v;
          end
        end
        if (poke_start && cur_vec == 2) start = 1'b1;
      end
      prev_sv = stim_valid;
      @(negedge clk);
      cycles++;
    end
    check("done_timeout", done, 1'b1);
    check("run_len", cycles, nvec * PER_VEC);
    check("queue_empty", exp_q.size(), 0);
    check("mismatch_cnt", mismatch_cnt, 16'(exp_bad));
    check("pass", pass, exp_bad == 0);
    check("fail_valid", fail_valid, first_seen);
    check("fail_idx", fail_idx, 16'(first_idx));
    check("fail_stim", fail_stim, first_stim);
    check("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_start = 1'b0; s_abort = 1'b0;
    cur_vec = -1; bad_vec = '0; m_lfsr = SEED;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_stim", stim, '0);
    check("rst_stim_valid", stim_valid, 1'b0);
    check("rst_mismatch", mismatch_cnt, 16'd0);
    check("rst_fail_valid", fail_valid, 1'b0);
    rst = 1'b0;

    // zero seed, all-mismatch, short run on the second instance
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0; cyc = 0;
    @(negedge clk); cyc++;
    check("seed0_word0", s_stim[31:0], 32'h1);
    @(negedge clk); cyc++;
    check("seed0_word1", s_stim[31:0], 32'h8020_0003);
    check("seed0_word0_shifted", s_stim[63:32], 32'h1);
    while (!s_done && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("small_len", cyc, S_NVEC * PER_VEC);
    check("small_mismatch", s_mismatch_cnt, 16'd4);
    check("small_fail_idx", s_fail_idx, 16'd0);
    check("small_fail_valid", s_fail_valid, 1'b1);
    check("small_pass", s_pass, 1'b0);
    check("small_busy", s_busy || s_stim_valid, 1'b0);

    // clean run with an ignored start mid-run
    bad_vec = '0;
    run_main(NUM_VEC, -1, 1'b1, cyc);

    // single corrupted vector, restarted from DONE
    bad_vec = '0; bad_vec[5] = 1'b1;
    run_main(NUM_VEC, -1, 1'b0, cyc);

    // abort during SETTLE of vector 3 after two mismatches
    bad_vec = '0; bad_vec[1] = 1'b1; bad_vec[2] = 1'b1;
    run_main(NUM_VEC, 3, 1'b0, cyc);

    // restart clears results, then asynchronous reset mid-DRIVE
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_clr_cnt", mismatch_cnt, 16'd0);
    check("restart_clr_fail", fail_valid, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_stim", stim, '0);
    @(negedge clk); rst = 1'b0;
    m_lfsr = SEED; exp_q.delete(); bad_vec = '0;
    run_main(NUM_VEC, -1, 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
